// File: rtl/regfile_pkg.sv
// Shared sizes and FSM state type for the register-file write arbiter.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    typedef enum logic {
        SWEEP,
        ARB
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (advance) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // After a grant the other requester gets priority; idle cycles keep it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write port: zero-fill sweep after reset/init, then
// round-robin arbitration of two write requesters with registered outputs.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              init_start,
    output logic              busy,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writeData
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [1:0]        grant;
    logic              advance;

    assign advance    = reset && (state == ARB) && !init_start;
    assign busy       = (state == SWEEP);
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   ({req1_valid, req0_valid}),
        .advance (advance),
        .grant   (grant)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= SWEEP;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SWEEP: if (cnt == LAST) state_next = ARB;
            ARB:   if (init_start) state_next = SWEEP;
            default: state_next = SWEEP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt          <= '0;
            rf_regWrite  <= 1'b0;
            rf_rd        <= '0;
            rf_writeData <= '0;
        end else if (state == SWEEP) begin
            rf_regWrite  <= 1'b1;
            rf_rd        <= cnt;
            rf_writeData <= '0;
            cnt          <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end else begin
            rf_regWrite  <= |grant;
            rf_rd        <= grant[1] ? req1_addr : req0_addr;
            rf_writeData <= grant[1] ? req1_data : req0_data;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: sweep, arbitration, init, reset.
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        init_start;
    logic        busy;
    logic        rf_regWrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_writeData;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .init_start   (init_start),
        .busy         (busy),
        .rf_regWrite  (rf_regWrite),
        .rf_rd        (rf_rd),
        .rf_writeData (rf_writeData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we,
                            input logic [4:0] rd, input logic [31:0] data);
        check({tag, "_we"}, 32'(rf_regWrite), 32'(we));
        if (we) begin
            check({tag, "_rd"}, 32'(rf_rd), 32'(rd));
            check({tag, "_data"}, rf_writeData, data);
        end
    endtask

    initial begin
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        req0_addr  = 5'd3;
        req0_data  = 32'h33;
        req1_addr  = 5'd0;
        req1_data  = 32'h0;
        init_start = 1'b0;

        // Reset held two cycles, requester pending throughout
        tick();
        tick();
        check("rst_we", 32'(rf_regWrite), 32'd0);
        check("rst_rd", 32'(rf_rd), 32'd0);
        check("rst_data", rf_writeData, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rdy0", 32'(req0_ready), 32'd0);

        // Full sweep; init_start mid-sweep must be ignored
        reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check_wr("sweep", 1'b1, 5'(i), 32'd0);
            check("sweep_busy", 32'(busy), (i < 31) ? 32'd1 : 32'd0);
            if (i < 31) check("sweep_rdy0", 32'(req0_ready), 32'd0);
            init_start = (i == 5);
            if (i == 30) req0_valid = 1'b0;
        end
        tick();
        check_wr("idle", 1'b0, 5'd0, 32'd0);

        // Single requester 0
        req0_valid = 1'b1;
        req0_addr  = 5'd5;
        req0_data  = 32'h55;
        #1;
        check("single_rdy0", 32'(req0_ready), 32'd1);
        check("single_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check_wr("single", 1'b1, 5'd5, 32'h55);
        tick();
        check_wr("single_after", 1'b0, 5'd0, 32'd0);

        // Single requester 1 to register 0, returns pointer to req0
        req1_valid = 1'b1;
        req1_addr  = 5'd0;
        req1_data  = 32'h1234;
        #1;
        check("r0_rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_wr("r0", 1'b1, 5'd0, 32'h1234);

        // Same address, pointer at req0
        req0_valid = 1'b1;
        req0_addr  = 5'd7;
        req0_data  = 32'hA;
        req1_valid = 1'b1;
        req1_addr  = 5'd7;
        req1_data  = 32'hB;
        #1;
        check("same_rdy0", 32'(req0_ready), 32'd1);
        check("same_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        check_wr("same_a", 1'b1, 5'd7, 32'hA);
        #1;
        check("same_rdy1b", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_wr("same_b", 1'b1, 5'd7, 32'hB);

        // Contention for four cycles
        req0_valid = 1'b1;
        req0_addr  = 5'd1;
        req0_data  = 32'd1;
        req1_valid = 1'b1;
        req1_addr  = 5'd2;
        req1_data  = 32'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("cont_rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_rdy1", 32'(req1_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            check_wr("cont", 1'b1, (k % 2 == 0) ? 5'd1 : 5'd2,
                     (k % 2 == 0) ? 32'd1 : 32'd2);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // init_start with req1 streaming
        req1_valid = 1'b1;
        req1_addr  = 5'd9;
        req1_data  = 32'h99;
        #1;
        check("init_pre_rdy1", 32'(req1_ready), 32'd1);
        tick();
        init_start = 1'b1;
        #1;
        check("init_rdy1", 32'(req1_ready), 32'd0);
        check_wr("init_prior", 1'b1, 5'd9, 32'h99);
        tick();
        init_start = 1'b0;
        check("init_busy", 32'(busy), 32'd1);
        check_wr("init_gap", 1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            check_wr("isweep", 1'b1, 5'(i), 32'd0);
            if (i < 31) check("isweep_rdy1", 32'(req1_ready), 32'd0);
        end
        #1;
        check("isweep_busy", 32'(busy), 32'd0);
        check("post_rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check_wr("post", 1'b1, 5'd9, 32'h99);

        // Reset in the middle of a sweep
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            check_wr("msweep", 1'b1, 5'(i), 32'd0);
        end
        reset = 1'b0;
        tick();
        check("mrst_we", 32'(rf_regWrite), 32'd0);
        check("mrst_rd", 32'(rf_rd), 32'd0);
        check("mrst_data", rf_writeData, 32'd0);
        req1_valid = 1'b1;
        #1;
        check("mrst_rdy1", 32'(req1_ready), 32'd0);
        check("mrst_busy", 32'(busy), 32'd1);
        tick();
        reset      = 1'b1;
        req1_valid = 1'b0;
        tick();
        check_wr("restart0", 1'b1, 5'd0, 32'd0);
        tick();
        check_wr("restart1", 1'b1, 5'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of registers swept at init.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the register index width.
REQ-003 The block SHALL have parameter DATA_W, default 32, giving the write data width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-low reset.
REQ-006 The block SHALL have ports req0_valid / req1_valid, input, 1, meaning requester i has a pending write.
REQ-007 The block SHALL have ports req0_addr / req1_addr, input, ADDR_W, the destination register index.
REQ-008 The block SHALL have ports req0_data / req1_data, input, DATA_W, the write data.
REQ-009 The block SHALL have ports req0_ready / req1_ready, output, 1, meaning the request is accepted this cycle.
REQ-010 The block SHALL have port init_start, input, 1, a pulse that requests a zero-fill sweep of all registers.
REQ-011 The block SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-012 The block SHALL have ports rf_regWrite (1), rf_rd (ADDR_W) and rf_writeData (DATA_W), outputs, driving the register file write port.

Function
REQ-013 The block SHALL have the states SWEEP and ARB.
REQ-014 In SWEEP, at each posedge the block SHALL register rf_regWrite=1, rf_rd=cnt and rf_writeData=0, then increment cnt.
REQ-015 When cnt==NUM_REGS-1 has been issued, the block SHALL go to ARB and clear cnt, so a sweep is exactly NUM_REGS consecutive write cycles.
REQ-016 busy SHALL equal (state==SWEEP), computed combinationally.
REQ-017 Both readies SHALL be 0 in SWEEP.
REQ-018 A request SHALL be accepted in cycle N when valid && ready are both high.
REQ-019 For a request accepted in cycle N, the block SHALL hold rf_regWrite=1 with that addr/data for exactly cycle N+1 (one-cycle latency, registered outputs).
REQ-020 This timing SHALL let the register file sample the outputs on the following negedge.
REQ-021 In ARB, rf_regWrite SHALL be 0 in any cycle following a cycle with no acceptance.
REQ-022 In ARB, at most one ready SHALL be high per cycle.
REQ-023 If only one requester is valid, its ready SHALL be high in that same cycle (combinational).
REQ-024 If both requesters are valid, the requester holding the round-robin pointer SHALL be granted.
REQ-025 After any grant to i, the pointer SHALL move to the other requester.
REQ-026 When the pointer is idle it SHALL be unchanged.
REQ-027 A requester SHALL hold valid, addr and data stable until it receives ready; the block relies on this and does not latch inputs before acceptance.
REQ-028 When both requesters target the same address, both writes SHALL be issued in grant order, so the later-granted data is final.
REQ-029 The block SHALL NOT merge or drop writes.
REQ-030 init_start sampled high in ARB SHALL suppress acceptance in that cycle and enter SWEEP at the next posedge.
REQ-031 A write accepted in the cycle before init_start SHALL still be issued before the sweep writes.
REQ-032 init_start high during SWEEP SHALL be ignored; the sweep does not restart.
REQ-033 Register index 0 SHALL be writable like any other register; there is no special casing.

Reset
REQ-034 While reset==0 at a posedge, the block SHALL set state=SWEEP, cnt=0 and pointer=req0.
REQ-035 While reset==0 at a posedge, the block SHALL set rf_regWrite=0, rf_rd=0 and rf_writeData=0.
REQ-036 During reset, readies SHALL be 0 and busy SHALL be 1.
REQ-037 Reset asserted mid-sweep or mid-arbitration SHALL abort the operation; after release a full sweep restarts from register 0.
REQ-038 The first sweep write SHALL appear after the first posedge with reset==1.

Structure
REQ-039 The package regfile_pkg SHALL hold ADDR_W, DATA_W, NUM_REGS and the state enum {SWEEP, ARB}.
REQ-040 The sub-module rr_arbiter2 SHALL implement the 2-way round-robin arbiter (inputs: valids, advance, pointer flop; outputs: one-hot grant).
REQ-041 The top level SHALL hold the FSM, the sweep counter and the output registers.

Verification
REQ-042 Reset scenario: reset low 2 cycles, then high -> 32 cycles of rf_regWrite=1 with rf_rd=0..31 and data 0; busy falls with the last write; readies 0 throughout.
REQ-043 Single requester: after the sweep, req0 writes addr 5, data 0x55 -> req0_ready in the same cycle; rf_regWrite/rf_rd=5/rf_writeData=0x55 for one cycle next.
REQ-044 Contention: both requesters valid for 4 cycles (req0 addr 1 data 1, req1 addr 2 data 2, each re-presenting after grant) -> grants alternate 0,1,0,1 and rf_rd follows 1,2,1,2.
REQ-045 Same address: req0 addr 7 data 0xA and req1 addr 7 data 0xB valid together, pointer at req0 -> writes 0xA then 0xB on consecutive cycles.
REQ-046 init_start mid-traffic: req1 valid continuously and init_start pulsed -> no ready that cycle; the prior accepted write is issued, then a 32-write zero sweep, then req1 is granted.
REQ-047 Reset mid-sweep: reset low at sweep index 10 -> outputs 0 during reset; after release the sweep restarts at rf_rd=0.
